// File: rtl/matrix_stream_sequencer.sv
// Turns a framed byte stream (rows, cols, then row-major elements) into
// addressed element writes for the matrix compiler, with header checking.
module matrix_stream_sequencer #(
  parameter int MAX_ROWS      = 32,
  parameter int MAX_COLS      = 32,
  parameter int ELEMENT_WIDTH = 8,
  localparam int ROW_W = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1,
  localparam int COL_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1
) (
  input  logic                     inter_refclk,
  input  logic                     rst,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     valid_data_out,
  output logic [ROW_W-1:0]         row_addr,
  output logic [COL_W-1:0]         col_addr,
  output logic [ELEMENT_WIDTH-1:0] matrix_element,
  output logic                     frame_done,
  output logic                     hdr_error,
  output logic                     busy
);

  typedef enum logic [1:0] {
    WAIT_ROWS = 2'd0,
    WAIT_COLS = 2'd1,
    STREAM    = 2'd2
  } state_t;

  // Limits compared against the full 8-bit header so oversize values are rejected.
  localparam logic [7:0] MAX_ROWS_B = 8'(MAX_ROWS);
  localparam logic [7:0] MAX_COLS_B = 8'(MAX_COLS);

  state_t           state_reg;
  logic [7:0]       n_rows_reg;
  logic [7:0]       n_cols_reg;
  logic [ROW_W-1:0] row_cnt_reg;
  logic [COL_W-1:0] col_cnt_reg;

  logic accept;
  logic last_col;
  logic last_row;

  assign in_ready = (state_reg == WAIT_ROWS) || (state_reg == WAIT_COLS) ||
                    (state_reg == STREAM);
  assign accept   = in_valid && in_ready;
  assign last_col = (8'(col_cnt_reg) == (n_cols_reg - 8'd1));
  assign last_row = (8'(row_cnt_reg) == (n_rows_reg - 8'd1));

  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      state_reg      <= WAIT_ROWS;
      n_rows_reg     <= '0;
      n_cols_reg     <= '0;
      row_cnt_reg    <= '0;
      col_cnt_reg    <= '0;
      valid_data_out <= 1'b0;
      row_addr       <= '0;
      col_addr       <= '0;
      matrix_element <= '0;
      frame_done     <= 1'b0;
      hdr_error      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      valid_data_out <= 1'b0;
      frame_done     <= 1'b0;
      hdr_error      <= 1'b0;
      if (accept) begin
        case (state_reg)
          WAIT_ROWS: begin
            n_rows_reg <= in_byte;
            if (in_byte == 8'd0 || in_byte > MAX_ROWS_B) begin
              hdr_error <= 1'b1;
            end else begin
              state_reg <= WAIT_COLS;
              busy      <= 1'b1;
            end
          end
          WAIT_COLS: begin
            n_cols_reg <= in_byte;
            if (in_byte == 8'd0 || in_byte > MAX_COLS_B) begin
              hdr_error <= 1'b1;
              busy      <= 1'b0;
              state_reg <= WAIT_ROWS;
            end else begin
              row_cnt_reg <= '0;
              col_cnt_reg <= '0;
              state_reg   <= STREAM;
            end
          end
          STREAM: begin
            valid_data_out <= 1'b1;
            matrix_element <= ELEMENT_WIDTH'(in_byte);
            row_addr       <= row_cnt_reg;
            col_addr       <= col_cnt_reg;
            if (last_col) begin
              col_cnt_reg <= '0;
              if (last_row) begin
                // Last element: frame closes in the same cycle the element appears.
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state_reg  <= WAIT_ROWS;
              end else begin
                row_cnt_reg <= row_cnt_reg + ROW_W'(1);
              end
            end else begin
              col_cnt_reg <= col_cnt_reg + COL_W'(1);
            end
          end
          default: state_reg <= WAIT_ROWS;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_sequencer.sv
// Directed bench: drives header/data bytes one step at a time and checks the
// registered outputs one cycle after each edge against hand-computed values.
module tb_matrix_stream_sequencer;

  logic       inter_refclk;
  logic       rst;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       valid_data_out;
  logic [4:0] row_addr;
  logic [4:0] col_addr;
  logic [7:0] matrix_element;
  logic       frame_done;
  logic       hdr_error;
  logic       busy;

  int tests_run;
  int failures;

  matrix_stream_sequencer #(
    .MAX_ROWS(32),
    .MAX_COLS(32),
    .ELEMENT_WIDTH(8)
  ) dut (
    .inter_refclk  (inter_refclk),
    .rst           (rst),
    .in_byte       (in_byte),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .valid_data_out(valid_data_out),
    .row_addr      (row_addr),
    .col_addr      (col_addr),
    .matrix_element(matrix_element),
    .frame_done    (frame_done),
    .hdr_error     (hdr_error),
    .busy          (busy)
  );

  initial inter_refclk = 1'b0;
  always #5 inter_refclk = ~inter_refclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock step: drive a byte (or a gap), then check what the edge produced.
  task automatic send(input string tag, input logic v, input logic [7:0] b,
                      input logic evd, input int er, input int ec, input logic [7:0] ee,
                      input logic efd, input logic ehe, input logic ebusy);
    in_valid = v;
    in_byte  = b;
    #1;
    chk({tag, ".in_ready"}, 16'(in_ready), 16'd1);
    @(posedge inter_refclk);
    #1;
    chk({tag, ".valid"}, 16'(valid_data_out), 16'(evd));
    chk({tag, ".frame_done"}, 16'(frame_done), 16'(efd));
    chk({tag, ".hdr_error"}, 16'(hdr_error), 16'(ehe));
    chk({tag, ".busy"}, 16'(busy), 16'(ebusy));
    if (evd) begin
      chk({tag, ".row"}, 16'(row_addr), 16'(er));
      chk({tag, ".col"}, 16'(col_addr), 16'(ec));
      chk({tag, ".elem"}, 16'(matrix_element), 16'(ee));
    end
    $display("[TB] %s v=%0b byte=%h -> vd=%0b r=%0d c=%0d e=%h fd=%0b he=%0b busy=%0b",
             tag, v, b, valid_data_out, row_addr, col_addr, matrix_element,
             frame_done, hdr_error, busy);
  endtask

  initial begin
    logic [1:0] gap_pat [7];
    int k;

    tests_run = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;

    // Reset state
    repeat (2) @(posedge inter_refclk);
    #1;
    chk("rst.valid", 16'(valid_data_out), 16'd0);
    chk("rst.row", 16'(row_addr), 16'd0);
    chk("rst.col", 16'(col_addr), 16'd0);
    chk("rst.elem", 16'(matrix_element), 16'd0);
    chk("rst.frame_done", 16'(frame_done), 16'd0);
    chk("rst.hdr_error", 16'(hdr_error), 16'd0);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.in_ready", 16'(in_ready), 16'd1);
    rst = 1'b0;

    // 2x3 frame
    send("f23.rows", 1, 8'h02, 0, 0, 0, 8'h00, 0, 0, 1);
    send("f23.cols", 1, 8'h03, 0, 0, 0, 8'h00, 0, 0, 1);
    send("f23.e0", 1, 8'h0A, 1, 0, 0, 8'h0A, 0, 0, 1);
    send("f23.e1", 1, 8'h0B, 1, 0, 1, 8'h0B, 0, 0, 1);
    send("f23.e2", 1, 8'h0C, 1, 0, 2, 8'h0C, 0, 0, 1);
    send("f23.e3", 1, 8'h0D, 1, 1, 0, 8'h0D, 0, 0, 1);
    send("f23.e4", 1, 8'h0E, 1, 1, 1, 8'h0E, 0, 0, 1);
    send("f23.e5", 1, 8'h0F, 1, 1, 2, 8'h0F, 1, 0, 0);
    send("f23.idle", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    // Bad headers
    send("bad.cols_rows", 1, 8'h02, 0, 0, 0, 8'h00, 0, 0, 1);
    send("bad.cols_zero", 1, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
    send("bad.rows_zero", 1, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
    send("bad.rows_33", 1, 8'h21, 0, 0, 0, 8'h00, 0, 1, 0);
    send("bad.rows_200", 1, 8'hC8, 0, 0, 0, 8'h00, 0, 1, 0);
    send("bad.rows_ok", 1, 8'h02, 0, 0, 0, 8'h00, 0, 0, 1);
    send("bad.cols_ok", 1, 8'h05, 0, 0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      send("f25.e", 1, 8'(8'h40 + i), 1, i / 5, i % 5, 8'(8'h40 + i),
           (i == 9), 0, (i != 9));
    end

    // in_valid gaps on a 1x4 frame
    send("gap.rows", 1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 1);
    send("gap.cols", 1, 8'h04, 0, 0, 0, 8'h00, 0, 0, 1);
    gap_pat = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01};
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (gap_pat[i][0]) begin
        send("gap.acc", 1, 8'(8'h20 + k), 1, 0, k, 8'(8'h20 + k), (k == 3), 0, (k != 3));
        k++;
      end else begin
        send("gap.idle", 0, 8'hFF, 0, 0, 0, 8'h00, 0, 0, 1);
        chk("gap.hold_col", 16'(col_addr), 16'(k - 1));
        chk("gap.hold_elem", 16'(matrix_element), 16'(8'h20 + k - 1));
      end
    end

    // Back-to-back 1x1 frames
    send("b2b.r1", 1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 1);
    send("b2b.c1", 1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 1);
    send("b2b.aa", 1, 8'hAA, 1, 0, 0, 8'hAA, 1, 0, 0);
    send("b2b.r2", 1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 1);
    send("b2b.c2", 1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 1);
    send("b2b.bb", 1, 8'hBB, 1, 0, 0, 8'hBB, 1, 0, 0);

    // 32x32 frame
    send("max.rows", 1, 8'h20, 0, 0, 0, 8'h00, 0, 0, 1);
    send("max.cols", 1, 8'h20, 0, 0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 1024; i++) begin
      send("max.e", 1, 8'(i), 1, i / 32, i % 32, 8'(i), (i == 1023), 0, (i != 1023));
    end

    // Reset mid-frame
    send("mid.rows", 1, 8'h04, 0, 0, 0, 8'h00, 0, 0, 1);
    send("mid.cols", 1, 8'h04, 0, 0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      send("mid.e", 1, 8'(8'h60 + i), 1, i / 4, i % 4, 8'(8'h60 + i), 0, 0, 1);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge inter_refclk);
    #1;
    rst = 1'b0;
    chk("mid.rst.valid", 16'(valid_data_out), 16'd0);
    chk("mid.rst.frame_done", 16'(frame_done), 16'd0);
    chk("mid.rst.busy", 16'(busy), 16'd0);
    send("mid.idle", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    send("mid.r", 1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 1);
    send("mid.c", 1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 1);
    send("mid.55", 1, 8'h55, 1, 0, 0, 8'h55, 1, 0, 0);
    send("mid.after", 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/matrix_stream_sequencer.md
Name: matrix_stream_sequencer

Overview:
- Sits directly upstream of the matrix compiler, in the inter_refclk domain.
- Accepts a framed byte stream from the host-side link over a valid/ready handshake. Each frame is a 2-byte dimension header followed by element bytes in row-major order.
- Emits one element per accepted data byte, tagged with its row and column address, on the compiler's element-load interface.
- Validates the header, pulses frame_done with the last element, and flags malformed headers.

Parameters:
- MAX_ROWS, 32, maximum rows per frame; legal range 1..255.
- MAX_COLS, 32, maximum columns per frame; legal range 1..255.
- ELEMENT_WIDTH, 8, width of one matrix element in bits; fixed at 8 because the input is byte-wide.

Ports:
- inter_refclk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_byte  input  8  stream byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  block can accept a byte this cycle.
- valid_data_out  output  1  element/address outputs are valid this cycle.
- row_addr  output  $clog2(MAX_ROWS)  row index of the element.
- col_addr  output  $clog2(MAX_COLS)  column index of the element.
- matrix_element  output  ELEMENT_WIDTH  element value.
- frame_done  output  1  one-cycle pulse, coincident with the last element of a frame.
- hdr_error  output  1  one-cycle pulse when a header dimension is illegal.
- busy  output  1  high from first header byte accepted until frame_done.

Behaviour:
- Reset: rst is synchronous, active-high, on inter_refclk. All outputs register to 0, except in_ready=1. State goes to WAIT_ROWS and counters clear.
- Accept rule: a byte is accepted on a rising edge where in_valid && in_ready. in_ready is combinationally 1 in WAIT_ROWS, WAIT_COLS and STREAM.
- No downstream backpressure: the consumer must take every valid_data_out cycle.
- WAIT_ROWS:
  - On accept, store n_rows = in_byte.
  - If in_byte == 0 or in_byte > MAX_ROWS: pulse hdr_error next cycle and stay in WAIT_ROWS.
  - Otherwise go to WAIT_COLS and set busy=1.
- WAIT_COLS:
  - On accept, store n_cols = in_byte.
  - If the value is illegal (0 or > MAX_COLS): pulse hdr_error, clear busy, return to WAIT_ROWS.
  - Otherwise clear row_cnt and col_cnt and go to STREAM.
- STREAM, on each accepted byte:
  - Next cycle: valid_data_out=1, matrix_element=in_byte, row_addr=row_cnt, col_addr=col_cnt. Latency is exactly 1 cycle from accept.
  - col_cnt increments. When col_cnt == n_cols-1, col_cnt wraps to 0 and row_cnt increments.
  - If row_cnt == n_rows-1 and col_cnt == n_cols-1 (last element): frame_done=1 in the same cycle as that element's valid_data_out, busy clears in the same cycle, and the state returns to WAIT_ROWS.
- No accept in a cycle: valid_data_out=0 the next cycle. Gaps in in_valid are allowed anywhere; state and counters hold.
- Back-to-back frames: the header byte of the next frame may be accepted the cycle right after the last data byte. No dead cycle is required or inserted.
- Output hold: row_addr, col_addr and matrix_element hold their last values when valid_data_out=0. Consumers must only sample them when valid_data_out=1.
- hdr_error and frame_done are never asserted in the same cycle.
- Reset mid-frame:
  - The partial frame is discarded, with no frame_done and no further valid_data_out.
  - The first byte accepted after reset is treated as a rows header.
- Address widths: counters are $clog2(MAX) bits. n_rows/n_cols comparisons use the full 8-bit header values, so oversize values (e.g. 200 with MAX_ROWS=32) are rejected, not truncated.

Test Plan:
- 2x3 frame: bytes 02,03,0A,0B,0C,0D,0E,0F, one per cycle -> six valid_data_out cycles with (row,col,element) = (0,0,0A) (0,1,0B) (0,2,0C) (1,0,0D) (1,1,0E) (1,2,0F). frame_done only with (1,2,0F). Each output appears 1 cycle after its accept.
- Bad header: rows byte 00 -> hdr_error pulse, no busy. Then rows 21 (33 > MAX_ROWS=32) -> hdr_error again. Then 02,05 -> busy=1, valid header. Also 02 followed by cols 00 -> hdr_error, return to WAIT_ROWS.
- in_valid gaps: 1x4 frame with in_valid toggling 1,0,0,1,0,1,1 -> outputs only on accept+1 cycles, col_addr 0,1,2,3, frame_done with col 3.
- Back-to-back: 1x1 frame (01,01,AA) immediately followed by 1x1 frame (01,01,BB) -> two frame_done pulses 3 cycles apart, elements AA then BB at (0,0).
- Max size: 32x32 frame of incrementing bytes -> 1024 outputs, last at row 31, col 31 with frame_done, and element value = (index mod 256).
- Reset mid-frame: after 5 data bytes of a 4x4 frame, assert rst for 1 cycle, then send 01,01,55 -> no frame_done for the aborted frame; a single output (0,0,55) with frame_done.
